// File: rtl/tetris_renderer.sv
// Two-stage pixel pipeline: maps the beam onto board, preview and border regions,
// queries the engine, blinks cleared lines and emits delay-matched RGB332 with syncs.
module tetris_renderer #(
  parameter int NUM_X        = 10,
  parameter int NUM_Y        = 20,
  parameter int CELL_LOG2    = 4,
  parameter int BOARD_X0     = 240,
  parameter int BOARD_Y0     = 40,
  parameter int BORDER       = 10,
  parameter int FLASH_FRAMES = 8,
  parameter int GRID         = 0,
  parameter int POS_W        = 8
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_pix_stb,
  input  logic [9:0]       i_x_in,
  input  logic [8:0]       i_y_in,
  input  logic             i_active_in,
  input  logic             i_hs_in,
  input  logic             i_vs_in,
  output logic [POS_W-1:0] o_query_pos,
  input  logic [2:0]       i_query_res,
  input  logic [NUM_Y-1:0] i_lines_cleared,
  input  logic [2:0]       i_next_piece,
  input  logic [15:0]      i_next_piece_matrix,
  input  logic             i_game_over,
  output logic [7:0]       o_rgb,
  output logic             o_hs,
  output logic             o_vs
);

  localparam int CELL  = 1 << CELL_LOG2;
  localparam int BX1   = BOARD_X0 + NUM_X * CELL;
  localparam int BY1   = BOARD_Y0 + NUM_Y * CELL;
  localparam int PX1   = BOARD_X0 - BORDER;
  localparam int PX0   = PX1 - 4 * CELL;
  localparam int PY0   = BOARD_Y0;
  localparam int PY1   = BOARD_Y0 + 4 * CELL;
  localparam int ROW_W = (NUM_Y > 1) ? $clog2(NUM_Y) : 1;
  localparam int CNT_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

  // Region tests are done on signed 32-bit copies of the beam, so nothing wraps left of an origin.
  function automatic logic inRect(input int x, input int y, input int x0, input int x1,
                                  input int y0, input int y1);
    return (x >= x0) && (x < x1) && (y >= y0) && (y < y1);
  endfunction

  function automatic logic [7:0] palette(input logic [2:0] id);
    case (id)
      3'd0:    return 8'h00;
      3'd1:    return 8'h18;
      3'd2:    return 8'h23;
      3'd3:    return 8'h27;
      3'd4:    return 8'hA8;
      3'd5:    return 8'h31;
      3'd6:    return 8'h78;
      default: return 8'h42;
    endcase
  endfunction

  int   w_x, w_y, w_dx, w_dy, w_col, w_rowTop, w_pCol, w_pRow;
  logic w_inBoard, w_boardRing, w_inPrev, w_prevRing, w_offX0, w_offY0, w_tick;
  logic [7:0] w_colour;

  logic             r_inBoard, r_boardRing, r_inPrev, r_prevRing;
  logic             r_offX0, r_offY0, r_active, r_hs1, r_vs1;
  logic [ROW_W-1:0] r_row;
  logic [3:0]       r_pIdx;
  logic [CNT_W-1:0] r_frameCnt;
  logic             r_blinkPhase;

  always_comb begin
    w_x         = {22'd0, i_x_in};
    w_y         = {23'd0, i_y_in};
    w_dx        = w_x - BOARD_X0;
    w_dy        = w_y - BOARD_Y0;
    w_col       = w_dx >>> CELL_LOG2;
    w_rowTop    = w_dy >>> CELL_LOG2;
    w_pCol      = (w_x - PX0) >>> CELL_LOG2;
    w_pRow      = (w_y - PY0) >>> CELL_LOG2;
    w_offX0     = (w_dx & (CELL - 1)) == 0;
    w_offY0     = (w_dy & (CELL - 1)) == 0;
    w_inBoard   = inRect(w_x, w_y, BOARD_X0, BX1, BOARD_Y0, BY1);
    w_boardRing = !w_inBoard && inRect(w_x, w_y, BOARD_X0 - BORDER, BX1 + BORDER,
                                       BOARD_Y0 - BORDER, BY1 + BORDER);
    w_inPrev    = inRect(w_x, w_y, PX0, PX1, PY0, PY1);
    w_prevRing  = !w_inPrev && inRect(w_x, w_y, PX0 - BORDER, PX1 + BORDER,
                                      PY0 - BORDER, PY1 + BORDER);
    w_tick      = i_pix_stb && (i_x_in == 10'd0) && (i_y_in == 9'd0);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_inBoard   <= 1'b0;
      r_boardRing <= 1'b0;
      r_inPrev    <= 1'b0;
      r_prevRing  <= 1'b0;
      r_offX0     <= 1'b0;
      r_offY0     <= 1'b0;
      r_active    <= 1'b0;
      r_hs1       <= 1'b1;
      r_vs1       <= 1'b1;
      r_row       <= '0;
      r_pIdx      <= '0;
      o_query_pos <= '0;
    end else if (i_pix_stb) begin
      r_inBoard   <= w_inBoard;
      r_boardRing <= w_boardRing;
      r_inPrev    <= w_inPrev;
      r_prevRing  <= w_prevRing;
      r_offX0     <= w_offX0;
      r_offY0     <= w_offY0;
      r_active    <= i_active_in;
      r_hs1       <= i_hs_in;
      r_vs1       <= i_vs_in;
      r_row       <= w_inBoard ? ROW_W'(NUM_Y - 1 - w_rowTop) : '0;
      r_pIdx      <= w_inPrev ? 4'(w_pRow * 4 + w_pCol) : 4'd0;
      o_query_pos <= w_inBoard ? POS_W'((NUM_Y - 1 - w_rowTop) * NUM_X + w_col) : '0;
    end
  end

  // An empty clear mask resets the blink on any clock, so a fresh clear always starts unblinked.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_frameCnt   <= '0;
      r_blinkPhase <= 1'b0;
    end else if (i_lines_cleared == '0) begin
      r_frameCnt   <= '0;
      r_blinkPhase <= 1'b0;
    end else if (w_tick) begin
      if (r_frameCnt == CNT_W'(FLASH_FRAMES - 1)) begin
        r_frameCnt   <= '0;
        r_blinkPhase <= ~r_blinkPhase;
      end else begin
        r_frameCnt <= r_frameCnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_colour = 8'h00;
    if (!r_active) begin
      w_colour = 8'h00;
    end else if (r_boardRing || r_prevRing) begin
      w_colour = i_game_over ? 8'hC0 : 8'h18;
    end else if (r_inPrev) begin
      if (i_next_piece_matrix[r_pIdx]) w_colour = palette(i_next_piece);
    end else if (r_inBoard) begin
      if (i_lines_cleared[r_row] && r_blinkPhase) w_colour = 8'hFF;
      else if ((GRID != 0) && (i_query_res != 3'd0) && (r_offX0 || r_offY0)) w_colour = 8'h00;
      else w_colour = palette(i_query_res);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_rgb <= 8'h00;
      o_hs  <= 1'b1;
      o_vs  <= 1'b1;
    end else if (i_pix_stb) begin
      o_rgb <= w_colour;
      o_hs  <= r_hs1;
      o_vs  <= r_vs1;
    end
  end

endmodule

// File: tb/tb_tetris_renderer.sv
// Randomised bench for tetris_renderer: two instances (default, and 2-frame blink with grid)
// are compared every clock against a region/palette reference model.
module tb_tetris_renderer;

  localparam int BX0  = 240;
  localparam int BY0  = 40;
  localparam int CELL = 16;
  localparam int NX   = 10;
  localparam int NY   = 20;
  localparam int BRD  = 10;
  localparam int PX0  = BX0 - BRD - 4 * CELL;

  logic        clk = 1'b0;
  logic        resetN = 1'b1;
  logic        pixStb = 1'b0;
  logic [9:0]  xIn = '0;
  logic [8:0]  yIn = '0;
  logic        activeIn = 1'b0;
  logic        hsIn = 1'b1;
  logic        vsIn = 1'b1;
  logic [19:0] linesCleared = '0;
  logic [2:0]  nextPiece = 3'd1;
  logic [15:0] nextMatrix = '0;
  logic        gameOver = 1'b0;

  logic [7:0] qPos0, qPos1, rgb0, rgb1;
  logic [2:0] qRes0, qRes1;
  logic       hs0, vs0, hs1, vs1;
  logic [2:0] boardMem [256];

  assign qRes0 = boardMem[qPos0];
  assign qRes1 = boardMem[qPos1];

  always #5 clk = ~clk;

  tetris_renderer dut0 (
    .i_clk(clk), .i_reset_n(resetN), .i_pix_stb(pixStb), .i_x_in(xIn), .i_y_in(yIn),
    .i_active_in(activeIn), .i_hs_in(hsIn), .i_vs_in(vsIn), .o_query_pos(qPos0),
    .i_query_res(qRes0), .i_lines_cleared(linesCleared), .i_next_piece(nextPiece),
    .i_next_piece_matrix(nextMatrix), .i_game_over(gameOver), .o_rgb(rgb0), .o_hs(hs0), .o_vs(vs0)
  );

  tetris_renderer #(.FLASH_FRAMES(2), .GRID(1)) dut1 (
    .i_clk(clk), .i_reset_n(resetN), .i_pix_stb(pixStb), .i_x_in(xIn), .i_y_in(yIn),
    .i_active_in(activeIn), .i_hs_in(hsIn), .i_vs_in(vsIn), .o_query_pos(qPos1),
    .i_query_res(qRes1), .i_lines_cleared(linesCleared), .i_next_piece(nextPiece),
    .i_next_piece_matrix(nextMatrix), .i_game_over(gameOver), .o_rgb(rgb1), .o_hs(hs1), .o_vs(vs1)
  );

  typedef struct {
    int   x;
    int   y;
    logic act;
    logic hs;
    logic vs;
  } pix_t;

  pix_t       prevPix;
  int         frameCnt [2];
  int         blinkPh [2];
  logic [7:0] expRgb [2];
  logic       expHs [2];
  logic       expVs [2];
  int         expQ [2];
  int         testsRun = 0;
  int         failCount = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic inBox(input int x, input int y, input int x0, input int x1,
                                 input int y0, input int y1);
    return (x >= x0) && (x < x1) && (y >= y0) && (y < y1);
  endfunction

  function automatic logic [7:0] pal(input logic [2:0] id);
    case (id)
      3'd0: return 8'h00;
      3'd1: return 8'h18;
      3'd2: return 8'h23;
      3'd3: return 8'h27;
      3'd4: return 8'hA8;
      3'd5: return 8'h31;
      3'd6: return 8'h78;
      default: return 8'h42;
    endcase
  endfunction

  function automatic int flashOf(input int d);
    return (d == 0) ? 8 : 2;
  endfunction

  function automatic logic inBoardArea(input int x, input int y);
    return inBox(x, y, BX0, BX0 + NX * CELL, BY0, BY0 + NY * CELL);
  endfunction

  function automatic int qposModel(input int x, input int y);
    if (!inBoardArea(x, y)) return 0;
    return (NY - 1 - (y - BY0) / CELL) * NX + (x - BX0) / CELL;
  endfunction

  // Expected colour of pixel p when its second stage runs with the current engine inputs.
  function automatic logic [7:0] colourModel(input int d, input pix_t p);
    logic       inB, inP, ringB, ringP;
    int         rowB, bitN;
    logic [2:0] q;
    if (!p.act) return 8'h00;
    inB   = inBoardArea(p.x, p.y);
    inP   = inBox(p.x, p.y, PX0, PX0 + 4 * CELL, BY0, BY0 + 4 * CELL);
    ringB = !inB && inBox(p.x, p.y, BX0 - BRD, BX0 + NX * CELL + BRD, BY0 - BRD, BY0 + NY * CELL + BRD);
    ringP = !inP && inBox(p.x, p.y, PX0 - BRD, PX0 + 4 * CELL + BRD, BY0 - BRD, BY0 + 4 * CELL + BRD);
    if (ringB || ringP) return gameOver ? 8'hC0 : 8'h18;
    if (inP) begin
      bitN = ((p.y - BY0) / CELL) * 4 + (p.x - PX0) / CELL;
      return nextMatrix[bitN] ? pal(nextPiece) : 8'h00;
    end
    if (inB) begin
      rowB = NY - 1 - (p.y - BY0) / CELL;
      q    = boardMem[qposModel(p.x, p.y)];
      if (linesCleared[rowB] && blinkPh[d] != 0) return 8'hFF;
      if (d == 1 && q != 3'd0 && ((p.x - BX0) % CELL == 0 || (p.y - BY0) % CELL == 0)) return 8'h00;
      return pal(q);
    end
    return 8'h00;
  endfunction

  task automatic checkAll(input string pfx);
    checkOutput({pfx, "Rgb0"}, 32'(rgb0), 32'(expRgb[0]));
    checkOutput({pfx, "Hs0"},  32'(hs0),  32'(expHs[0]));
    checkOutput({pfx, "Vs0"},  32'(vs0),  32'(expVs[0]));
    checkOutput({pfx, "Qpos0"}, 32'(qPos0), 32'(expQ[0]));
    checkOutput({pfx, "Rgb1"}, 32'(rgb1), 32'(expRgb[1]));
    checkOutput({pfx, "Hs1"},  32'(hs1),  32'(expHs[1]));
    checkOutput({pfx, "Vs1"},  32'(vs1),  32'(expVs[1]));
    checkOutput({pfx, "Qpos1"}, 32'(qPos1), 32'(expQ[1]));
  endtask

  // One clock: drive a pixel, advance the model across the rising edge, then compare.
  task automatic applyStimulus(input logic stb, input int x, input int y, input logic act,
                               input logic hs, input logic vs);
    pix_t cur;
    @(negedge clk);
    pixStb   = stb;
    xIn      = 10'(x);
    yIn      = 9'(y);
    activeIn = act;
    hsIn     = hs;
    vsIn     = vs;
    cur.x = x; cur.y = y; cur.act = act; cur.hs = hs; cur.vs = vs;
    if (stb) begin
      for (int d = 0; d < 2; d++) begin
        expRgb[d] = colourModel(d, prevPix);
        expHs[d]  = prevPix.hs;
        expVs[d]  = prevPix.vs;
        expQ[d]   = qposModel(x, y);
      end
      prevPix = cur;
    end
    for (int d = 0; d < 2; d++) begin
      if (linesCleared == '0) begin
        frameCnt[d] = 0;
        blinkPh[d]  = 0;
      end else if (stb && x == 0 && y == 0) begin
        if (frameCnt[d] == flashOf(d) - 1) begin
          frameCnt[d] = 0;
          blinkPh[d]  = 1 - blinkPh[d];
        end else begin
          frameCnt[d]++;
        end
      end
    end
    @(posedge clk);
    #1;
    checkAll("cyc");
  endtask

  task automatic modelReset();
    prevPix.x = 0; prevPix.y = 0; prevPix.act = 1'b0; prevPix.hs = 1'b1; prevPix.vs = 1'b1;
    for (int d = 0; d < 2; d++) begin
      frameCnt[d] = 0; blinkPh[d] = 0;
      expRgb[d] = 8'h00; expHs[d] = 1'b1; expVs[d] = 1'b1; expQ[d] = 0;
    end
  endtask

  // Reset lands mid-cycle and is held across a strobed edge with low syncs on the inputs.
  task automatic applyReset();
    @(negedge clk);
    #2 resetN = 1'b0;
    #1;
    modelReset();
    checkAll("rst");
    pixStb = 1'b1; hsIn = 1'b0; vsIn = 1'b0; activeIn = 1'b1; xIn = 10'd245; yIn = 9'd50;
    @(posedge clk);
    #1;
    checkAll("rstHold");
    @(negedge clk);
    resetN = 1'b1;
    pixStb = 1'b0;
  endtask

  initial begin
    int x, y;
    for (int i = 0; i < 256; i++) boardMem[i] = 3'($urandom_range(0, 7));
    boardMem[190] = 3'd3;
    boardMem[191] = 3'd3;
    boardMem[0]   = 3'd5;

    applyReset();

    applyStimulus(1, 240, 40, 1, 1, 1);
    checkOutput("originQpos", 32'(qPos0), 32'd190);
    applyStimulus(1, 300, 200, 1, 1, 1);
    checkOutput("originRgb", 32'(rgb0), 32'h27);

    gameOver = 1'b0;
    applyStimulus(1, 235, 100, 1, 1, 1);
    applyStimulus(1, 300, 200, 1, 1, 1);
    checkOutput("borderGreen", 32'(rgb0), 32'h18);
    gameOver = 1'b1;
    applyStimulus(1, 235, 100, 1, 1, 1);
    applyStimulus(1, 300, 200, 1, 1, 1);
    checkOutput("borderRed", 32'(rgb0), 32'hC0);
    gameOver = 1'b0;
    applyStimulus(1, 235, 100, 0, 1, 1);
    applyStimulus(1, 300, 200, 1, 1, 1);
    checkOutput("borderBlank", 32'(rgb0), 32'h00);

    nextMatrix = 16'h0033;
    nextPiece  = 3'd4;
    applyStimulus(1, PX0 + 16 + 3, BY0 + 5, 1, 1, 1);
    applyStimulus(1, 300, 200, 1, 1, 1);
    checkOutput("previewSet", 32'(rgb0), 32'hA8);
    applyStimulus(1, PX0 + 32 + 3, BY0 + 32 + 3, 1, 1, 1);
    applyStimulus(1, 300, 200, 1, 1, 1);
    checkOutput("previewClear", 32'(rgb0), 32'h00);

    applyStimulus(1, BX0 + 16, BY0 + 5, 1, 1, 1);
    applyStimulus(1, 300, 200, 1, 1, 1);
    checkOutput("gridLine", 32'(rgb1), 32'h00);
    checkOutput("noGridLine", 32'(rgb0), 32'h27);
    applyStimulus(1, BX0 + 17, BY0 + 5, 1, 1, 1);
    applyStimulus(1, 300, 200, 1, 1, 1);
    checkOutput("gridInside", 32'(rgb1), 32'h27);

    linesCleared = '0;
    applyStimulus(0, 300, 200, 1, 1, 1);
    linesCleared = 20'd1;
    for (int f = 1; f <= 6; f++) begin
      applyStimulus(1, 0, 0, 1, 1, 1);
      applyStimulus(1, 245, 350, 1, 1, 1);
      applyStimulus(1, 300, 200, 1, 1, 1);
      checkOutput($sformatf("blinkFrame%0d", f), 32'(rgb1),
                  (f == 2 || f == 3 || f == 6) ? 32'hFF : 32'h31);
    end
    linesCleared = '0;
    applyStimulus(1, 245, 350, 1, 1, 1);
    applyStimulus(1, 300, 200, 1, 1, 1);
    checkOutput("blinkCleared", 32'(rgb1), 32'h31);

    for (int i = 0; i < 48; i++) begin
      applyStimulus((i % 4) == 0, 300, 200, 1, ((i / 6) % 2) == 0, ((i / 10) % 2) == 0);
    end

    for (int i = 0; i < 1600; i++) begin
      if (i % 150 == 0) begin
        case ($urandom_range(0, 2))
          0:       linesCleared = '0;
          1:       linesCleared = 20'd1 << $urandom_range(0, 19);
          default: linesCleared = 20'($urandom);
        endcase
        gameOver   = 1'($urandom_range(0, 1));
        nextPiece  = 3'($urandom_range(1, 7));
        nextMatrix = 16'($urandom);
      end
      if (i == 800) applyReset();
      if ($urandom_range(0, 7) == 0) begin
        x = 0;
        y = 0;
      end else begin
        x = $urandom_range(150, 420);
        y = $urandom_range(25, 380);
      end
      applyStimulus($urandom_range(0, 3) != 0, x, y, $urandom_range(0, 7) != 0,
                    $urandom_range(0, 5) != 0, $urandom_range(0, 5) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
